// File: rtl/array_fifo_ctrl.sv
// ============================================================================
// array_fifo_ctrl
// ----------------------------------------------------------------------------
// Pointer and flag controller that turns a synchronous-write,
// combinational-read memory array into a first-word-fall-through FIFO.
// Storage lives in the external memory. This block holds only the read and
// write pointers, the occupancy count and the full/empty flags.
//
// Parameters:
//   WIDTH  data word width (must match the memory instance)
//   DEPTH  number of entries, any value >= 2 (power of two not required)
//   ADDR   address width, $clog2(DEPTH) (must match the memory instance)
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   in_data/in_valid/in_ready     producer side (push when in_valid & in_ready)
//   out_data/out_valid/out_ready  consumer side (pop when out_valid & out_ready)
//   mem_write_data/addr/en        memory write port (addr = write pointer)
//   mem_read_addr/mem_read_data   memory read port (addr = read pointer)
//   count, full, empty            occupancy (0..DEPTH) and status flags
//
// Optional feature (macro ARRAY_FIFO_CTRL_ERR_FLAGS_EN):
//   Adds sticky overflow_err (in_valid seen while full) and underflow_err
//   (out_ready seen while empty). Both clear only on rst_n. They never affect
//   pointer or count behaviour. When the macro is undefined, neither the
//   ports nor the logic exist.
// ============================================================================
module array_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mem_write_data,
    output logic [ADDR-1:0]  mem_write_addr,
    output logic             mem_write_en,
    output logic [ADDR-1:0]  mem_read_addr,
    input  logic [WIDTH-1:0] mem_read_data,
    output logic [ADDR:0]    count,
    output logic             full,
    output logic             empty
`ifdef ARRAY_FIFO_CTRL_ERR_FLAGS_EN
    ,
    output logic             overflow_err,
    output logic             underflow_err
`endif
);

    // Last legal address. Pointers wrap by explicit compare against it so a
    // non-power-of-two depth never reaches DEPTH.
    localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);
    localparam logic [ADDR-1:0] ZERO_ADDR = {ADDR{1'b0}};
    localparam logic [ADDR:0]   CNT_ZERO  = {(ADDR + 1){1'b0}};
    localparam logic [ADDR:0]   CNT_ONE   = (ADDR + 1)'(1);
    localparam logic [ADDR:0]   CNT_FULL  = (ADDR + 1)'(DEPTH);

    logic [ADDR-1:0] r_wr_ptr;
    logic [ADDR-1:0] r_rd_ptr;
    logic [ADDR:0]   r_count;
    logic            r_full;
    logic            r_empty;

    logic            w_push;
    logic            w_pop;
    logic [ADDR-1:0] w_wr_ptr_nxt;
    logic [ADDR-1:0] w_rd_ptr_nxt;
    logic [ADDR:0]   w_count_nxt;

    // Handshake qualification. in_valid is masked while rst_n is low so no
    // write reaches the memory during reset. The flags come from registers,
    // so in_ready and out_valid have no combinational input path.
    always_comb begin
        w_push = in_valid & ~r_full & rst_n;
        w_pop  = out_ready & ~r_empty;
    end

    // Next-pointer and next-count computation.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;

        if (w_push) begin
            if (r_wr_ptr == LAST_ADDR) begin
                w_wr_ptr_nxt = ZERO_ADDR;
            end else begin
                w_wr_ptr_nxt = r_wr_ptr + ADDR'(1);
            end
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end

        if (w_pop) begin
            if (r_rd_ptr == LAST_ADDR) begin
                w_rd_ptr_nxt = ZERO_ADDR;
            end else begin
                w_rd_ptr_nxt = r_rd_ptr + ADDR'(1);
            end
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            2'b11:   w_count_nxt = r_count;
            2'b00:   w_count_nxt = r_count;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer, count and flag registers. Flags are precomputed from the next
    // count so they are plain flops at the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= ZERO_ADDR;
            r_rd_ptr <= ZERO_ADDR;
            r_count  <= CNT_ZERO;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == CNT_FULL);
            r_empty  <= (w_count_nxt == CNT_ZERO);
        end
    end

`ifdef ARRAY_FIFO_CTRL_ERR_FLAGS_EN
    logic r_overflow_err;
    logic r_underflow_err;

    // Sticky error flags. They observe the handshake but never gate it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_overflow_err  <= r_overflow_err  | (in_valid  & r_full);
            r_underflow_err <= r_underflow_err | (out_ready & r_empty);
        end
    end

    assign overflow_err  = r_overflow_err;
    assign underflow_err = r_underflow_err;
`endif

    assign in_ready       = ~r_full;
    assign out_valid      = ~r_empty;
    assign out_data       = mem_read_data;
    assign mem_write_data = in_data;
    assign mem_write_addr = r_wr_ptr;
    assign mem_write_en   = w_push;
    assign mem_read_addr  = r_rd_ptr;
    assign count          = r_count;
    assign full           = r_full;
    assign empty          = r_empty;

endmodule
